commu_push_nw: RTL

//  Parametrised packet pusher: reads len_pkg bytes from the frame buffer (1-cycle read latency) and packs them into
//  BW_TX-bit words. Fires each word to the tx serialiser and waits for done_tx before the next word.

---
 rtl/commu_pkg.sv | 33 +++
 rtl/commu_pack.sv | 46 ++++
 rtl/commu_push_nw.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/commu_pkg.sv
// Shared definitions for the commu packet pusher: FSM state encodings and
// width helpers used to size the byte packer.
package commu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_CAP  = 3'd2,
        ST_FIRE = 3'd3,
        ST_WAIT = 3'd4,
        ST_NEXT = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    function automatic int nb_of(input int bw);
        return bw / 8;
    endfunction

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // A single-lane word still needs a 1-bit lane index
    function automatic int lane_w(input int nb);
        return (nb > 1) ? clog2_f(nb) : 1;
    endfunction

endpackage

// File: rtl/commu_pack.sv
// NB-lane byte packer: drops each captured byte into its lane of a BW_TX word.
// The word output already includes the byte captured in the current cycle.
module commu_pack
    import commu_pkg::*;
#(
    parameter int BW_TX = 16,
    parameter int LW    = lane_w(nb_of(BW_TX))
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             cap,
    input  logic [LW-1:0]    lane,
    input  logic             msb_first,
    input  logic [7:0]       din,
    output logic [BW_TX-1:0] word
);

    localparam int NB = nb_of(BW_TX);

    logic [BW_TX-1:0] word_r;
    logic [BW_TX-1:0] word_s;

    // Merge this cycle's byte; slot i holds byte NB-1-i when msb_first
    always_comb begin
        word_s = word_r;
        for (int i = 0; i < NB; i++) begin
            word_s[8*i +: 8] = (cap && (int'(lane) == (msb_first ? (NB - 1 - i) : i)))
                               ? din : word_r[8*i +: 8];
        end
    end

    // Lane storage, cleared between words
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            word_r <= {BW_TX{1'b0}};
        end else if (clr) begin
            word_r <= {BW_TX{1'b0}};
        end else begin
            word_r <= word_s;
        end
    end

    assign word = word_s;

endmodule

// File: rtl/commu_push_nw.sv
// Packet pusher: reads len_pkg bytes from the frame buffer, packs them into
// BW_TX-bit words and hands each word to the tx serialiser with handshake.
module commu_push_nw
    import commu_pkg::*;
#(
    parameter int BW_TX = 16,
    parameter int LEN_W = 16,
    parameter int TO_W  = 16
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             fire_push,
    input  logic             abort_push,
    output logic             done_push,
    output logic             err_push,
    output logic             buf_rd,
    input  logic [7:0]       buf_q,
    output logic             buf_frm,
    output logic             fire_tx,
    input  logic             done_tx,
    output logic [BW_TX-1:0] data_tx,
    input  logic [LEN_W-1:0] len_pkg,
    input  logic             cfg_msb_first,
    input  logic [TO_W-1:0]  cfg_timeout,
    output logic [LEN_W-1:0] cnt_word
);

    localparam int NB = nb_of(BW_TX);
    localparam int LW = lane_w(NB);
    localparam logic [LEN_W-1:0] NB_L = LEN_W'(NB);

    state_t           state_r, state_s;
    logic             err_s;
    logic [LEN_W-1:0] bytes_left_r, rd_cnt_r, cnt_word_r, k_s;
    logic [TO_W-1:0]  wait_cnt_r, to_r;
    logic             msb_r, rd_q_r, clr_s;
    logic [LW-1:0]    cap_idx_r;
    logic [BW_TX-1:0] word_s;
    logic             done_push_r, err_push_r, buf_rd_r, buf_frm_r, fire_tx_r;
    logic [BW_TX-1:0] data_tx_r;

    assign k_s   = (bytes_left_r > NB_L) ? NB_L : bytes_left_r;
    assign clr_s = (state_r == ST_IDLE) || (state_r == ST_NEXT) || (state_r == ST_DONE);

    // Next-state decode; err_s flags a DONE entered by abort or timeout
    always_comb begin
        state_s = state_r;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fire_push) begin
                    state_s = (len_pkg == {LEN_W{1'b0}}) ? ST_DONE : ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (abort_push) begin
                    state_s = ST_DONE;
                    err_s   = 1'b1;
                end else if (rd_cnt_r == k_s - LEN_W'(1)) begin
                    state_s = ST_CAP;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_CAP, ST_FIRE: begin
                if (abort_push) begin
                    state_s = ST_DONE;
                    err_s   = 1'b1;
                end else begin
                    state_s = (state_r == ST_CAP) ? ST_FIRE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort_push) begin
                    state_s = ST_DONE;
                    err_s   = 1'b1;
                end else if (done_tx) begin
                    state_s = ST_NEXT;
                end else if ((to_r != {TO_W{1'b0}}) && (wait_cnt_r == to_r - TO_W'(1))) begin
                    state_s = ST_DONE;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_NEXT: begin
                if (abort_push) begin
                    state_s = ST_DONE;
                    err_s   = 1'b1;
                end else if (bytes_left_r <= NB_L) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State and output registers, all decoded from the upcoming state
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            done_push_r <= 1'b0;
            err_push_r  <= 1'b0;
            buf_rd_r    <= 1'b0;
            buf_frm_r   <= 1'b0;
            fire_tx_r   <= 1'b0;
            data_tx_r   <= {BW_TX{1'b0}};
            rd_q_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            done_push_r <= (state_s == ST_DONE);
            err_push_r  <= err_s;
            buf_rd_r    <= (state_s == ST_READ);
            buf_frm_r   <= (state_s != ST_IDLE);
            fire_tx_r   <= (state_s == ST_FIRE);
            rd_q_r      <= buf_rd_r;
            if (state_s == ST_FIRE) begin
                data_tx_r <= word_s;
            end else if (state_s == ST_WAIT) begin
                data_tx_r <= data_tx_r;
            end else begin
                data_tx_r <= {BW_TX{1'b0}};
            end
        end
    end

    // Push configuration, byte/word/timeout counters and capture lane index
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            bytes_left_r <= {LEN_W{1'b0}};
            cnt_word_r   <= {LEN_W{1'b0}};
            rd_cnt_r     <= {LEN_W{1'b0}};
            wait_cnt_r   <= {TO_W{1'b0}};
            to_r         <= {TO_W{1'b0}};
            msb_r        <= 1'b0;
            cap_idx_r    <= {LW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fire_push) begin
                        bytes_left_r <= len_pkg;
                        to_r         <= cfg_timeout;
                        msb_r        <= cfg_msb_first;
                        cnt_word_r   <= {LEN_W{1'b0}};
                    end else begin
                        bytes_left_r <= bytes_left_r;
                    end
                end
                ST_NEXT: begin
                    bytes_left_r <= bytes_left_r - k_s;
                    cnt_word_r   <= cnt_word_r + LEN_W'(1);
                end
                default: bytes_left_r <= bytes_left_r;
            endcase
            rd_cnt_r   <= (state_r == ST_READ) ? rd_cnt_r + LEN_W'(1) : {LEN_W{1'b0}};
            wait_cnt_r <= (state_r == ST_WAIT) ? wait_cnt_r + TO_W'(1) : {TO_W{1'b0}};
            if (clr_s) begin
                cap_idx_r <= {LW{1'b0}};
            end else if (rd_q_r) begin
                cap_idx_r <= cap_idx_r + LW'(1);
            end else begin
                cap_idx_r <= cap_idx_r;
            end
        end
    end

    commu_pack #(
        .BW_TX (BW_TX),
        .LW    (LW)
    ) u_pack (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .clr       (clr_s),
        .cap       (rd_q_r),
        .lane      (cap_idx_r),
        .msb_first (msb_r),
        .din       (buf_q),
        .word      (word_s)
    );

    assign done_push = done_push_r;
    assign err_push  = err_push_r;
    assign buf_rd    = buf_rd_r;
    assign buf_frm   = buf_frm_r;
    assign fire_tx   = fire_tx_r;
    assign data_tx   = data_tx_r;
    assign cnt_word  = cnt_word_r;

endmodule
